// File: rtl/lsu_membuf.sv
// ---------------------------------------------------------------------------
// lsu_membuf
// Load/store unit that sits between the core's memory stage and the data
// memory port. Stores are posted into a small FIFO write buffer and drained
// in the background; loads wait for the buffer to empty (strict store-to-load
// ordering, no forwarding), then issue one read and return an extended result.
//
// Parameters:
//   N      datapath/address width (32 or 64)
//   DEPTH  store buffer entries (power of two, >= 2)
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   req_*             memory-stage request (valid, we, size, unsigned, addr, wdata)
//   stall             hold memory stage and earlier stages
//   load_valid/data   one-cycle load completion pulse and extended result
//   mem_*             ready/valid memory port (addr, wdata, mask, we, rdata, rvalid)
//   misalign          misaligned-access pulse
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned accesses pulse misalign and are dropped
//   undefined : low address bits are forced to the size alignment, misalign = 0
// ---------------------------------------------------------------------------
module lsu_membuf #(
    parameter int N     = 64,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req_valid,
    input  logic           req_we,
    input  logic [1:0]     req_size,
    input  logic           req_unsigned,
    input  logic [N-1:0]   req_addr,
    input  logic [N-1:0]   req_wdata,
    output logic           stall,
    output logic           load_valid,
    output logic [N-1:0]   load_data,
    output logic           mem_valid,
    input  logic           mem_ready,
    output logic           mem_we,
    output logic [N-1:0]   mem_addr,
    output logic [N-1:0]   mem_wdata,
    output logic [N/8-1:0] mem_mask,
    input  logic           mem_rvalid,
    input  logic [N-1:0]   mem_rdata,
    output logic           misalign
);

    localparam int NB = N / 8;
    localparam int OW = $clog2(NB);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, DRAIN, LREQ, LWAIT, LDONE} state_t;

    state_t         state;

    logic [N-1:0]   buf_addr  [DEPTH];
    logic [N-1:0]   buf_wdata [DEPTH];
    logic [NB-1:0]  buf_mask  [DEPTH];
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [PW:0]    count;
    logic           full;
    logic           empty;

    logic [1:0]     size_eff;
    logic [N-1:0]   lowmask;
    logic [N-1:0]   addr_al;
    logic [OW-1:0]  offset;
    logic [NB-1:0]  mask_base;
    logic [NB-1:0]  req_mask;
    logic [N-1:0]   req_lanes;
    logic [N-1:0]   req_wmasked;

    logic           new_req;
    logic           drop;
    logic           st_req;
    logic           ld_req;
    logic           push;
    logic           pop;
    logic           drain_act;

    logic [N-1:0]   load_addr;
    logic [OW-1:0]  load_off;
    logic [1:0]     load_size;
    logic           load_uns;
    logic [N-1:0]   rshift;
    logic [N-1:0]   ext;

    // Decode the request: effective size (dword folds to word on a 32-bit
    // datapath), size-aligned address, lane offset, byte mask and the write
    // data replicated across every lane and then masked down to the target bytes.
    always_comb begin
        size_eff = (N == 32 && req_size == 2'd3) ? 2'd2 : req_size;
        case (size_eff)
            2'd0:    begin lowmask = '0;     mask_base = NB'(8'h01); end
            2'd1:    begin lowmask = N'(1);  mask_base = NB'(8'h03); end
            2'd2:    begin lowmask = N'(3);  mask_base = NB'(8'h0F); end
            default: begin lowmask = N'(7);  mask_base = NB'(8'hFF); end
        endcase
        addr_al  = req_addr & ~lowmask;
        offset   = addr_al[OW-1:0];
        req_mask = mask_base << offset;
        case (size_eff)
            2'd0:    req_lanes = {NB{req_wdata[7:0]}};
            2'd1:    req_lanes = {(N/16){req_wdata[15:0]}};
            2'd2:    req_lanes = {(N/32){req_wdata[31:0]}};
            default: req_lanes = req_wdata;
        endcase
        for (int b = 0; b < NB; b++) begin
            req_wmasked[8*b +: 8] = req_mask[b] ? req_lanes[8*b +: 8] : 8'h00;
        end
    end

    // Misaligned accesses are either trapped and dropped, or simply proceed
    // with the already size-aligned address computed above.
`ifdef LSU_MISALIGN_TRAP_EN
    logic mis;
    assign mis  = |(req_addr & lowmask);
    assign drop = new_req & mis;
`else
    assign drop = 1'b0;
`endif
    assign misalign = drop;

    // Requests are only examined in IDLE; while the load FSM is busy the
    // pipeline is stalled and the presented request is the load in flight.
    // A full buffer blocks the store even if the head pops this same cycle.
    assign full      = (count == (PW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign new_req   = req_valid & (state == IDLE);
    assign st_req    = new_req & req_we & ~drop;
    assign ld_req    = new_req & ~req_we & ~drop;
    assign push      = st_req & ~full;
    assign drain_act = ((state == IDLE) || (state == DRAIN)) && !empty;
    assign pop       = drain_act & mem_ready;

    assign stall = (st_req & full) | ld_req |
                   (state == DRAIN) | (state == LREQ) | (state == LWAIT);

    // The memory port shows the buffer head while draining, the load word
    // address in LREQ, and zeros otherwise. Everything is derived from
    // registers, so the request stays stable until mem_ready.
    assign mem_valid = drain_act | (state == LREQ);
    assign mem_we    = drain_act;
    assign mem_addr  = drain_act ? buf_addr[head] :
                       (state == LREQ) ? load_addr : '0;
    assign mem_mask  = drain_act ? buf_mask[head] :
                       (state == LREQ) ? '1 : '0;
    assign mem_wdata = drain_act ? buf_wdata[head] : '0;

    // Buffer payload storage; needs no reset because head/tail/count decide
    // which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[tail]  <= {addr_al[N-1:OW], {OW{1'b0}}};
            buf_wdata[tail] <= req_wmasked;
            buf_mask[tail]  <= req_mask;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Shift the returned word so the addressed bytes sit at bit 0, then
    // sign- or zero-extend from the access size.
    always_comb begin
        rshift = mem_rdata >> {load_off, 3'b000};
        case (load_size)
            2'd0:    ext = load_uns ? N'(rshift[7:0])  : N'($signed(rshift[7:0]));
            2'd1:    ext = load_uns ? N'(rshift[15:0]) : N'($signed(rshift[15:0]));
            2'd2:    ext = load_uns ? N'(rshift[31:0]) : N'($signed(rshift[31:0]));
            default: ext = rshift;
        endcase
    end

    // Load FSM: capture the load in IDLE, wait out the store buffer, issue
    // the read, wait for data, then pulse load_valid for exactly one cycle
    // (LDONE), during which stall is low so the pipeline moves on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            load_valid <= 1'b0;
            load_data  <= '0;
            load_addr  <= '0;
            load_off   <= '0;
            load_size  <= 2'd0;
            load_uns   <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ld_req) begin
                        load_addr <= {addr_al[N-1:OW], {OW{1'b0}}};
                        load_off  <= offset;
                        load_size <= size_eff;
                        load_uns  <= req_unsigned;
                        state     <= empty ? LREQ : DRAIN;
                    end
                end
                DRAIN: begin
                    if (empty) state <= LREQ;
                end
                LREQ: begin
                    if (mem_ready) state <= LWAIT;
                end
                LWAIT: begin
                    if (mem_rvalid) begin
                        load_data  <= ext;
                        load_valid <= 1'b1;
                        state      <= LDONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
